// File: rtl/cell_mem_arb_pkg.sv
// Shared definitions for the cell memory arbiter: request opcodes, FSM
// states and the cell word layout used by the evaluator and the GC.
package cell_mem_arb_pkg;

    // Request opcodes carried on each channel's func field.
    typedef enum logic [1:0] {
        FN_GET   = 2'd0,
        FN_SET   = 2'd1,
        FN_ALLOC = 2'd2,
        FN_FLIP  = 2'd3
    } func_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RD_WAIT,
        ST_RD_DONE,
        ST_WR_DONE,
        ST_ALLOC_CHK,
        ST_GC_STALL
    } state_e;

    // Address 0 is NIL, so the first semispace starts right after it.
    localparam int NIL_ADDR = 0;

    // Cell word layout: 4-bit tag, 30-bit head, 30-bit tail.
    localparam int TAG_MSB  = 63;
    localparam int TAG_LSB  = 60;
    localparam int HEAD_MSB = 59;
    localparam int HEAD_LSB = 30;
    localparam int TAIL_MSB = 29;
    localparam int TAIL_LSB = 0;

endpackage

// File: rtl/cell_mem_arb_if.sv
// Requester / GC-engine bundle for the cell memory arbiter. The master
// side is the environment; the slave side is the arbiter itself.
interface cell_mem_arb_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int NUM_CH = 3
);
    logic                     power;
    logic [NUM_CH-1:0]        req;
    logic [2*NUM_CH-1:0]      func;
    logic [ADDR_W*NUM_CH-1:0] addr1;
    logic [ADDR_W*NUM_CH-1:0] addr2;
    logic [DATA_W*NUM_CH-1:0] wdata;
    logic [NUM_CH-1:0]        ack;
    logic [DATA_W-1:0]        rdata1;
    logic [DATA_W-1:0]        rdata2;
    logic [ADDR_W-1:0]        free_addr;
    logic                     gc_req;
    logic                     gc_done;
    logic [ADDR_W-1:0]        gc_free;
    logic                     space_sel;
    logic                     busy;

    modport master (
        output power, req, func, addr1, addr2, wdata, gc_done, gc_free,
        input  ack, rdata1, rdata2, free_addr, gc_req, space_sel, busy
    );

    modport slave (
        input  power, req, func, addr1, addr2, wdata, gc_done, gc_free,
        output ack, rdata1, rdata2, free_addr, gc_req, space_sel, busy
    );
endinterface

// File: rtl/cell_mem_arb_ram.sv
// Cell store: two synchronous read ports (one-cycle latency) and one write
// port. Everything holds while i_en is low.
module cell_mem_arb_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Write at the edge and register both read ports.
    // NOTE: the storage array has no reset; clearing every word would defeat
    // RAM inference and the heap contents must survive a controller reset.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            o_rdata1 <= r_mem[i_raddr1];
            o_rdata2 <= r_mem[i_raddr2];
        end
    end

endmodule

// File: rtl/cell_mem_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting channel
// at or after the pointer, wrapping modulo NUM_CH.
module rr_arbiter #(
    parameter  int NUM_CH = 3,
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_grant
);

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int k);
        return PTR_W'((int'(p) + k) % NUM_CH);
    endfunction

    // Scan from the farthest offset back to the pointer so the nearest requester wins.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves it unassigned would infer a latch.
        o_grant = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (i_req[wrap_idx(i_ptr, k)]) begin
                o_grant                   = '0;
                o_grant[wrap_idx(i_ptr, k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cell_mem_arb.sv
// Multi-requester cell memory: round-robin arbitration over NUM_CH channels,
// GET/SET on a 2R1W RAM, bump allocation inside the active semispace, and
// a GC request/stall handshake. Channel NUM_CH-1 is the GC channel.
module cell_mem_arb
    import cell_mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 64,
    parameter int NUM_CH      = 3,
    parameter int SPACE_WORDS = 160,
    parameter int SPACE1_BASE = 512
) (
    input  logic          clk,
    input  logic          rst,
    cell_mem_arb_if.slave bus
);

    localparam int                PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W-1:0]  GC_CH  = PTR_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] GC_BIT = NUM_CH'(1) << (NUM_CH - 1);

    state_e              r_state;
    func_e               r_func;
    logic [PTR_W-1:0]    r_ch;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [ADDR_W-1:0]   r_a1;
    logic [ADDR_W-1:0]   r_a2;
    logic [DATA_W-1:0]   r_wd;
    logic [ADDR_W-1:0]   r_free_ptr;
    logic [ADDR_W-1:0]   r_free_addr;
    logic [DATA_W-1:0]   r_rdata1;
    logic [DATA_W-1:0]   r_rdata2;
    logic [NUM_CH-1:0]   r_ack;
    logic [NUM_CH-1:0]   r_stall;
    logic                r_wren;
    logic                r_gc_req;
    logic                r_space;

    logic [1:0]          w_func [NUM_CH];
    logic [ADDR_W-1:0]   w_a1   [NUM_CH];
    logic [ADDR_W-1:0]   w_a2   [NUM_CH];
    logic [DATA_W-1:0]   w_wd   [NUM_CH];
    logic [NUM_CH-1:0]   w_elig;
    logic [NUM_CH-1:0]   w_grant;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_rr_next;
    logic [DATA_W-1:0]   w_ram_q1;
    logic [DATA_W-1:0]   w_ram_q2;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_len;
    logic [ADDR_W:0]     w_used;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_func[g] = bus.func[2*g +: 2];
        assign w_a1[g]   = bus.addr1[ADDR_W*g +: ADDR_W];
        assign w_a2[g]   = bus.addr2[ADDR_W*g +: ADDR_W];
        assign w_wd[g]   = bus.wdata[DATA_W*g +: DATA_W];
    end

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [PTR_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v     = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    // While a GC is pending only the GC channel may win, and not if it is the stalled one.
    assign w_elig = bus.req & (r_gc_req ? (GC_BIT & ~r_stall) : {NUM_CH{1'b1}});

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_req   (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    // Encode the one-hot grant into a channel index.
    always_comb begin
        w_win = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_grant[k]) w_win = PTR_W'(k);
        end
    end

    assign w_rr_next = (w_win == GC_CH) ? '0 : w_win + 1'b1;
    assign w_base    = r_space ? ADDR_W'(SPACE1_BASE) : ADDR_W'(NIL_ADDR + 1);
    assign w_len     = r_wd[ADDR_W-1:0];
    // One extra bit so free_ptr - base + len cannot wrap before the limit compare.
    assign w_used    = {1'b0, r_free_ptr} - {1'b0, w_base} + {1'b0, w_len};

    cell_mem_arb_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk      (clk),
        .i_en     (bus.power),
        .i_we     (r_wren),
        .i_waddr  (r_a1),
        .i_wdata  (r_wd),
        .i_raddr1 (r_a1),
        .i_raddr2 (r_a2),
        .o_rdata1 (w_ram_q1),
        .o_rdata2 (w_ram_q2)
    );

    // Controller FSM with registered outputs; gc_done is applied last so it overrides the FSM.
    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_func      <= FN_GET;
            r_ch        <= '0;
            r_rr_ptr    <= '0;
            r_a1        <= '0;
            r_a2        <= '0;
            r_wd        <= '0;
            r_free_ptr  <= ADDR_W'(NIL_ADDR + 1);
            r_free_addr <= '0;
            r_rdata1    <= '0;
            r_rdata2    <= '0;
            r_ack       <= '0;
            r_stall     <= '0;
            r_wren      <= 1'b0;
            r_gc_req    <= 1'b0;
            r_space     <= 1'b0;
        end else if (bus.power) begin
            r_ack  <= '0;
            r_wren <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_ch     <= w_win;
                        r_func   <= func_e'(w_func[w_win]);
                        r_a1     <= w_a1[w_win];
                        r_a2     <= w_a2[w_win];
                        r_wd     <= w_wd[w_win];
                        r_rr_ptr <= w_rr_next;
                        r_wren   <= (func_e'(w_func[w_win]) == FN_SET);
                        r_state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    case (r_func)
                        FN_GET:   r_state <= ST_RD_WAIT;
                        FN_SET:   r_state <= ST_WR_DONE;
                        FN_ALLOC: r_state <= ST_ALLOC_CHK;
                        FN_FLIP: begin
                            if (r_ch == GC_CH) r_space <= ~r_space;
                            r_state <= ST_WR_DONE;
                        end
                    endcase
                end
                ST_RD_WAIT: r_state <= ST_RD_DONE;
                ST_RD_DONE: begin
                    r_rdata1 <= w_ram_q1;
                    r_rdata2 <= w_ram_q2;
                    r_ack    <= ch_onehot(r_ch);
                    r_state  <= ST_IDLE;
                end
                ST_WR_DONE: begin
                    r_ack   <= ch_onehot(r_ch);
                    r_state <= ST_IDLE;
                end
                ST_ALLOC_CHK: begin
                    if (w_used <= (ADDR_W+1)'(SPACE_WORDS)) begin
                        r_free_addr <= r_free_ptr;
                        r_free_ptr  <= r_free_ptr + w_len;
                        r_ack       <= ch_onehot(r_ch);
                    end else begin
                        r_gc_req <= 1'b1;
                        r_stall  <= ch_onehot(r_ch);
                    end
                    r_state <= ST_IDLE;
                end
                // A failed allocation returns straight to IDLE so the GC channel
                // stays serviceable; ST_GC_STALL is never entered.
                default: r_state <= ST_IDLE;
            endcase
            if (bus.gc_done) begin
                r_free_ptr <= bus.gc_free;
                r_gc_req   <= 1'b0;
                r_stall    <= '0;
            end
        end
    end

    assign bus.ack       = r_ack;
    assign bus.rdata1    = r_rdata1;
    assign bus.rdata2    = r_rdata2;
    assign bus.free_addr = r_free_addr;
    assign bus.gc_req    = r_gc_req;
    assign bus.space_sel = r_space;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cell_mem_arb.sv
// Directed bench for cell_mem_arb: a vector table for single operations
// plus hand-written sequences for arbitration, GC stall and reset abort.
module tb_cell_mem_arb;
    import cell_mem_arb_pkg::*;

    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 64;
    localparam int NUM_CH      = 3;
    localparam int SPACE_WORDS = 160;
    localparam int SPACE1_BASE = 512;

    localparam logic [63:0] C_BEEF = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] C_PAT  = 64'h1234_5678_9ABC_DEF0;

    typedef struct {
        int          ch;
        func_e       fn;
        int          a1;
        int          a2;
        logic [63:0] wd;
        int          lat;
        bit          chk_rd;
        logic [63:0] r1;
        logic [63:0] r2;
        bit          chk_fa;
        int          fa;
        bit          space;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    cell_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    cell_mem_arb #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_CH      (NUM_CH),
        .SPACE_WORDS (SPACE_WORDS),
        .SPACE1_BASE (SPACE1_BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int ch, input func_e fn, input int a1, input int a2,
                         input logic [63:0] wd);
        bus.func[ch*2 +: 2]            = fn;
        bus.addr1[ch*ADDR_W +: ADDR_W] = ADDR_W'(a1);
        bus.addr2[ch*ADDR_W +: ADDR_W] = ADDR_W'(a2);
        bus.wdata[ch*DATA_W +: DATA_W] = wd;
        bus.req[ch]                    = 1'b1;
    endtask

    // Waits for ack on channel ch; n is the number of edges it took.
    task automatic wait_ack(input int ch, input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            tick();
            n++;
            if (bus.ack[ch]) ok = 1'b1;
        end
    endtask

    task automatic watch(input int cycles, output logic [NUM_CH-1:0] seen);
        seen = '0;
        repeat (cycles) begin
            tick();
            seen |= bus.ack;
        end
    endtask

    task automatic pulse_gc_done(input int free);
        bus.gc_free = ADDR_W'(free);
        bus.gc_done = 1'b1;
        tick();
        bus.gc_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},       64'(bus.ack), 64'd0);
        check({tag, "_rdata1"},    bus.rdata1, 64'd0);
        check({tag, "_rdata2"},    bus.rdata2, 64'd0);
        check({tag, "_free_addr"}, 64'(bus.free_addr), 64'd0);
        check({tag, "_gc_req"},    64'(bus.gc_req), 64'd0);
        check({tag, "_space_sel"}, 64'(bus.space_sel), 64'd0);
        check({tag, "_busy"},      64'(bus.busy), 64'd0);
    endtask

    function automatic vec_t mk(int ch, func_e fn, int a1, int a2, logic [63:0] wd, int lat,
                                bit chk_rd, logic [63:0] r1, logic [63:0] r2,
                                bit chk_fa, int fa, bit space);
        vec_t v;
        v.ch = ch; v.fn = fn; v.a1 = a1; v.a2 = a2; v.wd = wd; v.lat = lat;
        v.chk_rd = chk_rd; v.r1 = r1; v.r2 = r2;
        v.chk_fa = chk_fa; v.fa = fa; v.space = space;
        return v;
    endfunction

    // ack must never be asserted on more than one channel.
    always @(negedge clk) begin
        if (rst) check("ack_onehot0", 64'($onehot0(bus.ack)), 64'd1);
    end

    initial begin
        vec_t              vecs[$];
        int                n;
        bit                ok;
        int                prev;
        int                got;
        logic [NUM_CH-1:0] seen;

        // ch, fn, a1, a2, wdata, ticks to ack, rd?, r1, r2, fa?, fa, space_sel
        vecs.push_back(mk(0, FN_SET,   0, 0, 64'd0,  3, 0, 0,      0,      0, 0, 0));
        vecs.push_back(mk(0, FN_SET,   5, 0, C_BEEF, 3, 0, 0,      0,      0, 0, 0));
        vecs.push_back(mk(0, FN_GET,   5, 0, 64'd0,  4, 1, C_BEEF, 64'd0,  0, 0, 0));
        vecs.push_back(mk(1, FN_SET,   9, 0, C_PAT,  3, 0, 0,      0,      0, 0, 0));
        vecs.push_back(mk(2, FN_GET,   9, 5, 64'd0,  4, 1, C_PAT,  C_BEEF, 0, 0, 0));
        vecs.push_back(mk(0, FN_ALLOC, 0, 0, 64'd4,  3, 0, 0,      0,      1, 1, 0));
        vecs.push_back(mk(1, FN_ALLOC, 0, 0, 64'd4,  3, 0, 0,      0,      1, 5, 0));
        vecs.push_back(mk(0, FN_ALLOC, 0, 0, 64'd0,  3, 0, 0,      0,      1, 9, 0));
        vecs.push_back(mk(0, FN_ALLOC, 0, 0, 64'd3,  3, 0, 0,      0,      1, 9, 0));
        vecs.push_back(mk(1, FN_FLIP,  0, 0, 64'd0,  3, 0, 0,      0,      0, 0, 0));

        bus.power   = 1'b1;
        bus.req     = '0;
        bus.func    = '0;
        bus.addr1   = '0;
        bus.addr2   = '0;
        bus.wdata   = '0;
        bus.gc_done = 1'b0;
        bus.gc_free = '0;

        repeat (3) tick();
        check_reset_outputs("rst0");
        rst = 1'b1;
        tick();

        // Single operations from the table, each starting from IDLE.
        foreach (vecs[i]) begin
            issue(vecs[i].ch, vecs[i].fn, vecs[i].a1, vecs[i].a2, vecs[i].wd);
            wait_ack(vecs[i].ch, 20, n, ok);
            bus.req[vecs[i].ch] = 1'b0;
            check($sformatf("v%0d_ack", i), 64'(ok), 64'd1);
            check($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].lat));
            if (vecs[i].chk_rd) begin
                check($sformatf("v%0d_rdata1", i), bus.rdata1, vecs[i].r1);
                check($sformatf("v%0d_rdata2", i), bus.rdata2, vecs[i].r2);
            end
            if (vecs[i].chk_fa)
                check($sformatf("v%0d_free_addr", i), 64'(bus.free_addr), 64'(vecs[i].fa));
            check($sformatf("v%0d_space_sel", i), 64'(bus.space_sel), 64'(vecs[i].space));
            tick();
        end

        // ch0 and ch1 request GET continuously: service must alternate.
        issue(0, FN_GET, 5, 0, 64'd0);
        issue(1, FN_GET, 9, 0, 64'd0);
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            n  = 0;
            ok = 1'b0;
            while (n < 20 && !ok) begin
                tick();
                n++;
                ok = |bus.ack[1:0];
            end
            check($sformatf("rr%0d_ack", k), 64'(ok), 64'd1);
            got = bus.ack[1] ? 1 : 0;
            if (k > 0) check($sformatf("rr%0d_alternate", k), 64'(got), 64'(1 - prev));
            check($sformatf("rr%0d_rdata1", k), bus.rdata1, (got == 0) ? C_BEEF : C_PAT);
            prev = got;
        end
        bus.req = '0;
        tick();

        // A request withdrawn during GRANT is still completed and acked.
        issue(1, FN_SET, 20, 0, 64'h55);
        tick();
        bus.req[1] = 1'b0;
        wait_ack(1, 10, n, ok);
        check("drop_req_ack", 64'(ok), 64'd1);
        tick();
        issue(0, FN_GET, 20, 0, 64'd0);
        wait_ack(0, 10, n, ok);
        bus.req[0] = 1'b0;
        check("drop_req_written", bus.rdata1, 64'h55);
        tick();

        // Fill space 0 exactly: free_ptr 12, used = 11 + 149 = 160.
        issue(0, FN_ALLOC, 0, 0, 64'd149);
        wait_ack(0, 10, n, ok);
        bus.req[0] = 1'b0;
        check("fill_ack", 64'(ok), 64'd1);
        check("fill_free_addr", 64'(bus.free_addr), 64'd12);
        tick();

        // Overflowing alloc stalls ch0 and raises gc_req.
        issue(0, FN_ALLOC, 0, 0, 64'd200);
        watch(8, seen);
        check("ovf_gc_req", 64'(bus.gc_req), 64'd1);
        check("ovf_no_ack_ch0", 64'(seen[0]), 64'd0);

        issue(1, FN_GET, 5, 0, 64'd0);
        watch(8, seen);
        check("gc_ch1_blocked", 64'(seen[1]), 64'd0);

        issue(2, FN_GET, 5, 0, 64'd0);
        wait_ack(2, 10, n, ok);
        bus.req[2] = 1'b0;
        check("gc_ch2_get_ack", 64'(ok), 64'd1);
        check("gc_ch2_rdata1", bus.rdata1, C_BEEF);
        tick();

        issue(2, FN_FLIP, 0, 0, 64'd0);
        wait_ack(2, 10, n, ok);
        bus.req[2] = 1'b0;
        check("flip_ack", 64'(ok), 64'd1);
        check("flip_latency", 64'(n), 64'd3);
        check("flip_space_sel", 64'(bus.space_sel), 64'd1);
        tick();

        // GC completes; the retry of len 200 still fails (8 + 200 > 160).
        pulse_gc_done(520);
        check("gc_done_clears_req", 64'(bus.gc_req), 64'd0);
        watch(10, seen);
        check("retry_reraises_gc_req", 64'(bus.gc_req), 64'd1);
        check("retry_no_ack", 64'(seen), 64'd0);

        // With len 100 the retry fits; ch1 is ahead of ch0 in round-robin order.
        bus.wdata[0*DATA_W +: DATA_W] = 64'd100;
        pulse_gc_done(520);
        wait_ack(1, 20, n, ok);
        bus.req[1] = 1'b0;
        check("resume_ch1_ack", 64'(ok), 64'd1);
        check("resume_ch1_rdata1", bus.rdata1, C_BEEF);
        wait_ack(0, 20, n, ok);
        bus.req[0] = 1'b0;
        check("resume_ch0_ack", 64'(ok), 64'd1);
        check("resume_ch0_free_addr", 64'(bus.free_addr), 64'd520);
        check("resume_gc_req", 64'(bus.gc_req), 64'd0);
        tick();

        issue(2, FN_ALLOC, 0, 0, 64'd0);
        wait_ack(2, 10, n, ok);
        bus.req[2] = 1'b0;
        check("len0_space1_free_addr", 64'(bus.free_addr), 64'd620);
        tick();

        // Reset during the GRANT cycle of a SET suppresses the write.
        issue(0, FN_SET, 7, 0, 64'hAAAA);
        wait_ack(0, 10, n, ok);
        bus.req[0] = 1'b0;
        tick();
        issue(0, FN_SET, 7, 0, 64'hBBBB);
        tick();
        check("rst_mid_busy", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1;
        bus.req[0] = 1'b0;
        check_reset_outputs("rst_mid");
        tick();
        tick();
        rst = 1'b1;
        tick();
        issue(0, FN_GET, 7, 0, 64'd0);
        wait_ack(0, 10, n, ok);
        bus.req[0] = 1'b0;
        check("rst_word_kept", bus.rdata1, 64'hAAAA);
        tick();
        issue(0, FN_ALLOC, 0, 0, 64'd2);
        wait_ack(0, 10, n, ok);
        bus.req[0] = 1'b0;
        check("rst_free_ptr", 64'(bus.free_addr), 64'd1);
        tick();

        // power low freezes the controller; work resumes once it returns.
        bus.power = 1'b0;
        issue(0, FN_GET, 5, 0, 64'd0);
        watch(5, seen);
        check("power_off_no_ack", 64'(seen), 64'd0);
        check("power_off_idle", 64'(bus.busy), 64'd0);
        bus.power = 1'b1;
        wait_ack(0, 10, n, ok);
        bus.req[0] = 1'b0;
        check("power_on_latency", 64'(n), 64'd4);
        check("power_on_rdata1", bus.rdata1, C_BEEF);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
